axis_len_prefix: RTL and testbench

//  Store-and-forward AXI-Stream framer, directly upstream of data_io. Buffers one

---
 rtl/axis_len_prefix.sv | 174 +++++++++++++++++
 tb/tb_axis_len_prefix.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_len_prefix.sv
// =============================================================================
// axis_len_prefix : store-and-forward AXI-Stream framer (count header + payload)
// Revision 1.0 : initial release
// =============================================================================
`default_nettype none

module axis_len_prefix #(
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                S_AXIS_ACLK,
  input  logic                S_AXIS_ARESETN,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0] S_AXIS_TKEEP,
  input  logic                S_AXIS_TLAST,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
  output logic                M_AXIS_TLAST,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY,
  output logic                overflow,
  output logic                busy
);

  localparam int c_DEPTH = 1 << DEPTH_LOG2;
  localparam int c_CNT_W = DEPTH_LOG2 + 1;

  localparam logic [c_CNT_W-1:0]    c_FULL    = c_CNT_W'(c_DEPTH);
  localparam logic [c_CNT_W-1:0]    c_CNT_ONE = c_CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = DEPTH_LOG2'(1);

  localparam logic [1:0] c_ST_FILL  = 2'd0;
  localparam logic [1:0] c_ST_HDR   = 2'd1;
  localparam logic [1:0] c_ST_DRAIN = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]    r_count;
  logic                  r_overflow;
  logic [DATA_W-1:0]     r_mem [c_DEPTH];

  logic w_rx;
  logic w_tx;
  logic w_nonnull;
  logic w_full;
  logic w_store;
  logic w_drop;
  logic w_last_word;

  assign w_rx        = S_AXIS_TVALID & S_AXIS_TREADY;
  assign w_tx        = M_AXIS_TVALID & M_AXIS_TREADY;
  assign w_nonnull   = |S_AXIS_TKEEP;
  assign w_full      = (r_count == c_FULL);
  assign w_store     = w_rx & w_nonnull & ~w_full;
  assign w_drop      = w_rx & w_nonnull & w_full;
  assign w_last_word = ({1'b0, r_rd_ptr} == (r_count - c_CNT_ONE));

  assign overflow = r_overflow;
  assign busy     = (r_state != c_ST_FILL);

  // State register
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      r_state <= c_ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_FILL: begin
        if (w_rx && S_AXIS_TLAST) begin
          w_state_nxt = c_ST_HDR;
        end
      end
      c_ST_HDR: begin
        if (w_tx) begin
          w_state_nxt = (r_count == '0) ? c_ST_FILL : c_ST_DRAIN;
        end
      end
      c_ST_DRAIN: begin
        if (w_tx && w_last_word) begin
          w_state_nxt = c_ST_FILL;
        end
      end
      default: w_state_nxt = c_ST_FILL;
    endcase
  end

  // Outputs depend only on registered state, so they hold while stalled
  always_comb begin
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TDATA  = '0;
    M_AXIS_TKEEP  = '0;
    M_AXIS_TLAST  = 1'b0;
    case (r_state)
      c_ST_FILL: begin
        S_AXIS_TREADY = 1'b1;
      end
      c_ST_HDR: begin
        M_AXIS_TVALID              = 1'b1;
        M_AXIS_TDATA[c_CNT_W-1:0]  = r_count;
        M_AXIS_TKEEP               = '1;
        M_AXIS_TLAST               = (r_count == '0);
      end
      c_ST_DRAIN: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = r_mem[r_rd_ptr];
        M_AXIS_TKEEP  = '1;
        M_AXIS_TLAST  = w_last_word;
      end
      default: ;
    endcase
  end

  // Pointers, word count and sticky truncation flag
  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        c_ST_FILL: begin
          if (w_store) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            r_count  <= r_count + c_CNT_ONE;
          end
          if (w_drop) begin
            r_overflow <= 1'b1;
          end else if (w_rx && (r_count == '0)) begin
            r_overflow <= 1'b0;
          end
        end
        c_ST_HDR: begin
          if (w_tx && (r_count != '0)) begin
            r_rd_ptr <= '0;
          end
        end
        c_ST_DRAIN: begin
          if (w_tx) begin
            if (w_last_word) begin
              r_wr_ptr <= '0;
              r_rd_ptr <= '0;
              r_count  <= '0;
            end else begin
              r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Packet buffer; contents need no reset since pointers gate every read
  always_ff @(posedge S_AXIS_ACLK) begin
    if (w_store) begin
      r_mem[r_wr_ptr] <= S_AXIS_TDATA;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_len_prefix.sv
// =============================================================================
// tb_axis_len_prefix : directed self-checking bench for axis_len_prefix
// Revision 1.0 : initial release
// =============================================================================
`default_nettype none

module tb_axis_len_prefix;

  logic        r_clk = 1'b0;
  logic        r_rst_n;
  logic        r_sel;
  logic [15:0] r_s_data;
  logic [1:0]  r_s_keep;
  logic        r_s_last;
  logic        r_s_valid;
  logic        r_m_ready;

  logic        w_a_srdy, w_a_last, w_a_vld, w_a_ovf, w_a_busy;
  logic [15:0] w_a_data;
  logic [1:0]  w_a_keep;
  logic        w_b_srdy, w_b_last, w_b_vld, w_b_ovf, w_b_busy;
  logic [15:0] w_b_data;
  logic [1:0]  w_b_keep;

  logic        w_srdy, w_last, w_vld, w_ovf, w_busy;
  logic [15:0] w_data;
  logic [1:0]  w_keep;

  int n_tot = 0;
  int n_bad = 0;

  logic [15:0] q_d[$];
  logic [1:0]  q_k[$];
  logic        q_l[$];
  logic [16:0] q_e[$];

  always #5 r_clk = ~r_clk;

  axis_len_prefix #(.DATA_W(16), .DEPTH_LOG2(8)) u_dut_a (
    .S_AXIS_ACLK    (r_clk),
    .S_AXIS_ARESETN (r_rst_n),
    .S_AXIS_TDATA   (r_s_data),
    .S_AXIS_TKEEP   (r_s_keep),
    .S_AXIS_TLAST   (r_s_last),
    .S_AXIS_TVALID  (r_s_valid & ~r_sel),
    .S_AXIS_TREADY  (w_a_srdy),
    .M_AXIS_TDATA   (w_a_data),
    .M_AXIS_TKEEP   (w_a_keep),
    .M_AXIS_TLAST   (w_a_last),
    .M_AXIS_TVALID  (w_a_vld),
    .M_AXIS_TREADY  (r_m_ready),
    .overflow       (w_a_ovf),
    .busy           (w_a_busy)
  );

  axis_len_prefix #(.DATA_W(16), .DEPTH_LOG2(2)) u_dut_b (
    .S_AXIS_ACLK    (r_clk),
    .S_AXIS_ARESETN (r_rst_n),
    .S_AXIS_TDATA   (r_s_data),
    .S_AXIS_TKEEP   (r_s_keep),
    .S_AXIS_TLAST   (r_s_last),
    .S_AXIS_TVALID  (r_s_valid & r_sel),
    .S_AXIS_TREADY  (w_b_srdy),
    .M_AXIS_TDATA   (w_b_data),
    .M_AXIS_TKEEP   (w_b_keep),
    .M_AXIS_TLAST   (w_b_last),
    .M_AXIS_TVALID  (w_b_vld),
    .M_AXIS_TREADY  (r_m_ready),
    .overflow       (w_b_ovf),
    .busy           (w_b_busy)
  );

  assign w_srdy = r_sel ? w_b_srdy : w_a_srdy;
  assign w_data = r_sel ? w_b_data : w_a_data;
  assign w_keep = r_sel ? w_b_keep : w_a_keep;
  assign w_last = r_sel ? w_b_last : w_a_last;
  assign w_vld  = r_sel ? w_b_vld  : w_a_vld;
  assign w_ovf  = r_sel ? w_b_ovf  : w_a_ovf;
  assign w_busy = r_sel ? w_b_busy : w_a_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic push_in(input logic [15:0] d, input logic [1:0] k, input logic l);
    q_d.push_back(d);
    q_k.push_back(k);
    q_l.push_back(l);
  endtask

  task automatic push_exp(input logic [15:0] d, input logic l);
    q_e.push_back({l, d});
  endtask

  task automatic clr_q();
    q_d.delete();
    q_k.delete();
    q_l.delete();
    q_e.delete();
  endtask

  // mode 0: downstream always ready, 1: ready toggles, 2: ready held low
  task automatic run(input int mode, input bit chk_lat);
    int          idx     = 0;
    int          oidx    = 0;
    int          cyc     = 0;
    int          acc_cyc = -1;
    int          tx0     = -1;
    int          txn     = -1;
    logic        stalled = 1'b0;
    logic [16:0] held    = '0;
    while ((idx < q_d.size() || oidx < q_e.size()) && cyc < 300) begin
      @(negedge r_clk);
      if (stalled) chk("hold", {15'd0, w_last, w_data}, {15'd0, held});
      r_m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'b0;
      if (idx < q_d.size()) begin
        r_s_valid = 1'b1;
        r_s_data  = q_d[idx];
        r_s_keep  = q_k[idx];
        r_s_last  = q_l[idx];
      end else begin
        r_s_valid = 1'b0;
        r_s_data  = '0;
        r_s_keep  = '0;
        r_s_last  = 1'b0;
      end
      if (w_vld) begin
        chk("keep", {30'd0, w_keep}, 32'd3);
        chk("no_overlap", {31'd0, w_srdy}, 32'd0);
      end
      if (r_s_valid && w_srdy) begin
        if (r_s_last) acc_cyc = cyc;
        idx++;
      end
      if (w_vld && r_m_ready) begin
        if (oidx < q_e.size()) chk("beat", {15'd0, w_last, w_data}, {15'd0, q_e[oidx]});
        else                   chk("extra_beat", 32'd1, 32'd0);
        if (tx0 < 0) tx0 = cyc;
        txn = cyc;
        oidx++;
      end
      stalled = w_vld && !r_m_ready;
      held    = {w_last, w_data};
      cyc++;
    end
    if (cyc >= 300) chk("timeout", 32'd1, 32'd0);
    if (mode != 2) begin
      @(negedge r_clk);
      chk("rdy_after", {31'd0, w_srdy}, 32'd1);
      chk("vld_after", {31'd0, w_vld}, 32'd0);
      if (chk_lat) begin
        chk("latency", 32'(tx0 - acc_cyc), 32'd1);
        chk("burst", 32'(txn - tx0), 32'(q_e.size() - 1));
      end
    end
  endtask

  initial begin
    r_rst_n   = 1'b0;
    r_sel     = 1'b0;
    r_s_data  = '0;
    r_s_keep  = '0;
    r_s_last  = 1'b0;
    r_s_valid = 1'b0;
    r_m_ready = 1'b1;
    repeat (3) @(negedge r_clk);
    chk("rst_vld", {31'd0, w_vld}, 32'd0);
    r_rst_n = 1'b1;
    @(negedge r_clk);
    chk("rst_srdy", {31'd0, w_srdy}, 32'd1);
    chk("rst_data", {16'd0, w_data}, 32'd0);
    chk("rst_keep", {30'd0, w_keep}, 32'd0);
    chk("rst_last", {31'd0, w_last}, 32'd0);
    chk("rst_ovf",  {31'd0, w_ovf},  32'd0);
    chk("rst_busy", {31'd0, w_busy}, 32'd0);
    chk("rst_ovf_b", {31'd0, w_b_ovf}, 32'd0);

    // basic three-word packet, free-flowing
    clr_q();
    push_in(16'd3, 2'b11, 1'b0); push_in(16'd5, 2'b11, 1'b0); push_in(16'd7, 2'b11, 1'b1);
    push_exp(16'd3, 1'b0); push_exp(16'd3, 1'b0); push_exp(16'd5, 1'b0); push_exp(16'd7, 1'b1);
    run(0, 1'b1);
    chk("t1_ovf", {31'd0, w_ovf}, 32'd0);

    // same packet with downstream back-pressure
    run(1, 1'b0);

    // null beat mid-packet and a partial-keep word
    clr_q();
    push_in(16'd9, 2'b11, 1'b0); push_in(16'hdead, 2'b00, 1'b0); push_in(16'd4, 2'b01, 1'b1);
    push_exp(16'd2, 1'b0); push_exp(16'd9, 1'b0); push_exp(16'd4, 1'b1);
    run(0, 1'b1);

    // lone null beat carrying TLAST gives an empty frame
    clr_q();
    push_in(16'hbeef, 2'b00, 1'b1);
    push_exp(16'd0, 1'b1);
    run(0, 1'b1);

    // back-to-back packets with input held valid
    clr_q();
    push_in(16'h11, 2'b11, 1'b0); push_in(16'h22, 2'b11, 1'b1); push_in(16'h33, 2'b11, 1'b1);
    push_exp(16'd2, 1'b0); push_exp(16'h11, 1'b0); push_exp(16'h22, 1'b1);
    push_exp(16'd1, 1'b0); push_exp(16'h33, 1'b1);
    run(0, 1'b0);

    // truncation on the four-word instance
    r_sel = 1'b1;
    clr_q();
    for (int i = 1; i <= 6; i++) push_in(16'(i), 2'b11, (i == 6));
    push_exp(16'd4, 1'b0); push_exp(16'd1, 1'b0); push_exp(16'd2, 1'b0);
    push_exp(16'd3, 1'b0); push_exp(16'd4, 1'b1);
    run(0, 1'b1);
    chk("t4_ovf_set", {31'd0, w_ovf}, 32'd1);
    clr_q();
    push_in(16'd7, 2'b11, 1'b1);
    push_exp(16'd1, 1'b0); push_exp(16'd7, 1'b1);
    run(0, 1'b1);
    chk("t4_ovf_clr", {31'd0, w_ovf}, 32'd0);
    r_sel = 1'b0;

    // reset while draining
    clr_q();
    push_in(16'd1, 2'b11, 1'b0); push_in(16'd2, 2'b11, 1'b0); push_in(16'd3, 2'b11, 1'b1);
    run(2, 1'b0);
    @(negedge r_clk);
    r_s_valid = 1'b0;
    r_s_last  = 1'b0;
    r_m_ready = 1'b1;
    chk("t5_hdr_busy", {31'd0, w_busy}, 32'd1);
    chk("t5_hdr", {16'd0, w_data}, 32'd3);
    @(negedge r_clk);
    chk("t5_drain", {16'd0, w_data}, 32'd1);
    r_m_ready = 1'b0;
    #2 r_rst_n = 1'b0;
    #1;
    chk("t5_rst_vld",  {31'd0, w_vld},  32'd0);
    chk("t5_rst_keep", {30'd0, w_keep}, 32'd0);
    chk("t5_rst_busy", {31'd0, w_busy}, 32'd0);
    @(negedge r_clk);
    r_rst_n = 1'b1;
    clr_q();
    push_in(16'd8, 2'b11, 1'b1);
    push_exp(16'd1, 1'b0); push_exp(16'd8, 1'b1);
    run(0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
